// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester and its surroundings:
//   - FSM state encoding of the requester (IDLE / SETUP / ACCESS)
//   - default address / data widths of the APB register bus
//   - address map of the 8-bit APB register slave (registers 0x00..0x07)
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic [7:0] REG_ADDR_0 = 8'h00;
  localparam logic [7:0] REG_ADDR_1 = 8'h01;
  localparam logic [7:0] REG_ADDR_2 = 8'h02;
  localparam logic [7:0] REG_ADDR_3 = 8'h03;
  localparam logic [7:0] REG_ADDR_4 = 8'h04;
  localparam logic [7:0] REG_ADDR_5 = 8'h05;
  localparam logic [7:0] REG_ADDR_6 = 8'h06;
  localparam logic [7:0] REG_ADDR_7 = 8'h07;

endpackage

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
// APB initiator: takes one read/write command at a time from a valid/ready
// command port, runs the APB SETUP and ACCESS phases, waits through slave wait
// states and returns a one-cycle response pulse with read data and error flag.
//
// Optional build macro: APB_REQ_TIMEOUT_EN
//   When defined, an ACCESS phase that sees pready=0 for TIMEOUT_CYCLES
//   consecutive cycles is aborted and answered with rsp_err=1, rsp_rdata=0.
//   When undefined, ACCESS waits for pready indefinitely.
//
// Ports:
//   pclk, presetn          clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_write/addr/wdata   command fields, latched on acceptance
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata, rsp_err     read data (0 for writes) and error; held until the
//                          next completion
//   psel/penable/pwrite/paddr/pwdata   registered APB request outputs
//   pready/pslverr/prdata  APB slave response inputs
// -----------------------------------------------------------------------------
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_REQ_TIMEOUT_EN
  // Abort fires on the wait cycle that would bring the count to the limit.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

  // Ready is withheld during the response pulse so that accepted commands are
  // always at least four cycles apart and a new request never shares a cycle
  // with the previous completion.
  assign cmd_ready = presetn && (state_q == ST_IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_REQ_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_REQ_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_REQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_REQ_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
// Directed bench for apb_requester with a behavioural 8-register APB slave
// whose wait-state count and stuck-pready behaviour are set per scenario.
// Build with APB_REQ_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=4).
// -----------------------------------------------------------------------------
module tb_apb_requester;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready, pslverr;
  logic [7:0] prdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  // ---------------- behavioural APB slave ----------------
  int         wait_states = 2;
  bit         stuck = 1'b0;
  int         acc_cnt = 0;
  logic [7:0] regs [0:7];

  assign pready  = psel && penable && !stuck && (acc_cnt >= wait_states);
  assign pslverr = pready && (paddr > 8'h07);
  assign prdata  = (pready && paddr <= 8'h07) ? regs[paddr[2:0]] : 8'h00;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && paddr <= 8'h07)
      regs[paddr[2:0]] <= pwdata;
  end

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  // Drives a command for one cycle; returns at the negedge of the SETUP cycle.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge pclk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  // Counts negedges (starting with the current one) until rsp_valid, bounded.
  task automatic wait_rsp(input int max, output int n, output bit got);
    n = 0; got = 1'b0;
    while (!got && n < max) begin
      if (rsp_valid) got = 1'b1;
      else begin n++; @(negedge pclk); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    tests++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b want=00000", {psel, penable, pwrite, rsp_valid, rsp_err});
    end
    tests++;
    if ({paddr, pwdata, rsp_rdata} !== 24'h0) begin
      fails++; $display("FAIL reset_data got=%h want=000000", {paddr, pwdata, rsp_rdata});
    end
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready got=%b want=0", cmd_ready);
    end
    presetn = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset got=%b want=1", cmd_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_write();
    int  n_acc = 0;
    bit  got = 1'b0;
    wait_states = 2; stuck = 1'b0;
    @(negedge pclk);
    cmd_write = 1'b1; cmd_addr = 8'h03; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL write_ready got=%b want=1", cmd_ready);
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
    tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h03, 8'hA5}) begin
      fails++; $display("FAIL write_setup got=%h want=%h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 8'h03, 8'hA5});
    end
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL setup_ready got=%b want=0", cmd_ready);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge pclk);
      if (rsp_valid) got = 1'b1;
      else begin
        n_acc++;
        tests++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b111, 8'h03, 8'hA5}) begin
          fails++; $display("FAIL write_access got=%h want=%h", {psel, penable, pwrite, paddr, pwdata}, {3'b111, 8'h03, 8'hA5});
        end
      end
    end
    tests++;
    if (got !== 1'b1 || n_acc != 3) begin
      fails++; $display("FAIL write_latency got=%0b/%0d want=1/3", got, n_acc);
    end
    tests++;
    if ({rsp_err, rsp_rdata, psel, penable} !== {1'b0, 8'h00, 2'b00}) begin
      fails++; $display("FAIL write_rsp got=%h want=%h", {rsp_err, rsp_rdata, psel, penable}, {1'b0, 8'h00, 2'b00});
    end
    @(negedge pclk);
    tests++;
    if ({rsp_valid, rsp_err} !== 2'b00) begin
      fails++; $display("FAIL write_pulse got=%b want=00", {rsp_valid, rsp_err});
    end
    $display("[TB] write addr=03 data=A5 access_cycles=%0d err=%b", n_acc, rsp_err);
  endtask

  task automatic test_read_back();
    int n; bit got;
    wait_states = 2;
    issue(1'b0, 8'h03, 8'h00);
    wait_rsp(20, n, got);
    tests++;
    if ({got, rsp_err, rsp_rdata} !== {2'b10, 8'hA5} || n != 4) begin
      fails++; $display("FAIL read_back got=%b/%b/%h/%0d want=1/0/a5/4", got, rsp_err, rsp_rdata, n);
    end
    $display("[TB] read addr=03 data=%h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_slverr();
    int n; bit got;
    issue(1'b0, 8'h09, 8'h00);
    wait_rsp(20, n, got);
    tests++;
    if ({got, rsp_err, rsp_rdata} !== {2'b11, 8'h00}) begin
      fails++; $display("FAIL slverr got=%b/%b/%h want=1/1/00", got, rsp_err, rsp_rdata);
    end
    @(negedge pclk);
    tests++;
    if (rsp_err !== 1'b1) begin
      fails++; $display("FAIL err_hold got=%b want=1", rsp_err);
    end
    $display("[TB] read addr=09 data=%h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int rsp_cyc[$];
    bit drop = 1'b0;
    wait_states = 0;
    @(negedge pclk);
    cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
      if (rsp_valid) rsp_cyc.push_back(cyc);
      if (acc_cyc.size() == 3) drop = 1'b1;
      @(negedge pclk);
      if (drop) cmd_valid = 1'b0;
    end
    tests++;
    if (acc_cyc.size() != 3 || rsp_cyc.size() != 3) begin
      fails++; $display("FAIL b2b_count got=%0d/%0d want=3/3", acc_cyc.size(), rsp_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rsp_cyc[i] - acc_cyc[i] != 3) begin
          fails++; $display("FAIL b2b_latency[%0d] got=%0d want=3", i, rsp_cyc[i] - acc_cyc[i]);
        end
        if (i > 0) begin
          tests++;
          if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
            fails++; $display("FAIL b2b_spacing[%0d] got=%0d want=4", i, acc_cyc[i] - acc_cyc[i-1]);
          end
        end
        $display("[TB] b2b write addr=04 accept=%0d rsp=%0d", acc_cyc[i], rsp_cyc[i]);
      end
    end
    tests++;
    if (regs[4] !== 8'h5A) begin
      fails++; $display("FAIL b2b_reg got=%h want=5a", regs[4]);
    end
  endtask

  task automatic test_reset_access();
    int n; bit got; bit seen = 1'b0;
    wait_states = 3;
    issue(1'b1, 8'h01, 8'h11);
    wait_rsp(20, n, got);
    $display("[TB] write addr=01 data=11 err=%b", rsp_err);
    issue(1'b1, 8'h01, 8'h77);
    @(negedge pclk);
    tests++;
    if ({psel, penable} !== 2'b11) begin
      fails++; $display("FAIL abort_in_access got=%b want=11", {psel, penable});
    end
    presetn = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL abort_ready_comb got=%b want=0", cmd_ready);
    end
    @(negedge pclk);
    tests++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
      fails++; $display("FAIL abort_edge got=%b want=0000", {psel, penable, rsp_valid, cmd_ready});
    end
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL abort_release got=%b want=1", cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rsp_valid || psel) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL abort_quiet got=%b want=0", seen);
    end
    issue(1'b0, 8'h01, 8'h00);
    wait_rsp(20, n, got);
    tests++;
    if ({got, rsp_err, rsp_rdata} !== {2'b10, 8'h11}) begin
      fails++; $display("FAIL abort_reg got=%b/%b/%h want=1/0/11", got, rsp_err, rsp_rdata);
    end
    $display("[TB] aborted write addr=01, read back data=%h", rsp_rdata);
  endtask

`ifdef APB_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit got;
    stuck = 1'b1;
    issue(1'b0, 8'h03, 8'h00);
    wait_rsp(30, n, got);
    tests++;
    if ({got, rsp_err, rsp_rdata, psel, penable} !== {2'b11, 8'h00, 2'b00} || n != 5) begin
      fails++; $display("FAIL timeout got=%b/%b/%h/%b/%0d want=1/1/00/00/5", got, rsp_err, rsp_rdata, {psel, penable}, n);
    end
    $display("[TB] timeout read addr=03 err=%b", rsp_err);
    stuck = 1'b0; wait_states = 3;
    issue(1'b0, 8'h03, 8'h00);
    wait_rsp(30, n, got);
    tests++;
    if ({got, rsp_err, rsp_rdata} !== {2'b10, 8'hA5} || n != 5) begin
      fails++; $display("FAIL timeout_edge got=%b/%b/%h/%0d want=1/0/a5/5", got, rsp_err, rsp_rdata, n);
    end
    $display("[TB] limit-cycle read addr=03 data=%h err=%b", rsp_rdata, rsp_err);
  endtask
`else
  task automatic test_no_timeout();
    int n; bit got;
    stuck = 1'b1;
    issue(1'b0, 8'h02, 8'h00);
    wait_rsp(30, n, got);
    tests++;
    if ({got, psel, penable} !== 3'b011) begin
      fails++; $display("FAIL no_timeout_hold got=%b want=011", {got, psel, penable});
    end
    stuck = 1'b0; wait_states = 0;
    wait_rsp(5, n, got);
    tests++;
    if ({got, rsp_err, rsp_rdata} !== {2'b10, 8'h00}) begin
      fails++; $display("FAIL no_timeout_done got=%b/%b/%h want=1/0/00", got, rsp_err, rsp_rdata);
    end
    $display("[TB] long-wait read addr=02 data=%h err=%b", rsp_rdata, rsp_err);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_back();
    test_slverr();
    test_back_to_back();
    test_reset_access();
`ifdef APB_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
